// File: rtl/eth_mmio_arbiter_if.sv
// eth_mmio_arbiter_if: requester-side and controller-side MMIO signals of the arbiter.
// slave  = arbiter side (takes requests, drives the controller port)
// master = environment side (requesters plus the controller model)
interface eth_mmio_arbiter_if #(
  parameter int num_req_p    = 2,
  parameter int addr_width_p = 16,
  parameter int axis_width_p = 64
);
  logic [num_req_p-1:0]                   req_v_i;
  logic [num_req_p-1:0]                   req_ready_o;
  logic [num_req_p-1:0][addr_width_p-1:0] req_addr_i;
  logic [num_req_p-1:0]                   req_write_i;
  logic [num_req_p-1:0][1:0]              req_op_size_i;
  logic [num_req_p-1:0][axis_width_p-1:0] req_data_i;
  logic [num_req_p-1:0]                   resp_v_o;
  logic [axis_width_p-1:0]                resp_data_o;
  logic                                   resp_err_o;
  logic [addr_width_p-1:0]                addr_o;
  logic                                   write_en_o;
  logic                                   read_en_o;
  logic [1:0]                             op_size_o;
  logic [axis_width_p-1:0]                write_data_o;
  logic [axis_width_p-1:0]                read_data_i;
  logic                                   read_data_v_i;

  modport slave (
    input  req_v_i, req_addr_i, req_write_i, req_op_size_i, req_data_i,
           read_data_i, read_data_v_i,
    output req_ready_o, resp_v_o, resp_data_o, resp_err_o,
           addr_o, write_en_o, read_en_o, op_size_o, write_data_o
  );

  modport master (
    output req_v_i, req_addr_i, req_write_i, req_op_size_i, req_data_i,
           read_data_i, read_data_v_i,
    input  req_ready_o, resp_v_o, resp_data_o, resp_err_o,
           addr_o, write_en_o, read_en_o, op_size_o, write_data_o
  );
endinterface

// File: rtl/eth_mmio_arbiter.sv
// eth_mmio_arbiter: round-robin share of the controller MMIO port, one op in flight.
// Optional read timeout: define ETH_MMIO_ARB_TIMEOUT_EN to enable it; a read that sits
// in RWAIT for timeout_cycles_p cycles completes with all-ones data and resp_err_o=1.
module eth_mmio_arbiter #(
  parameter int num_req_p        = 2,
  parameter int addr_width_p     = 16,
  parameter int axis_width_p     = 64,
  parameter int timeout_cycles_p = 256
) (
  input logic                 clk_i,
  input logic                 reset_i,
  eth_mmio_arbiter_if.slave   bus
);
  localparam int ptr_w = $clog2(num_req_p);

  typedef enum logic [2:0] {IDLE, ISSUE, WACK, RWAIT, RRESP} state_e;

  state_e                   state_r, state_n;
  logic [ptr_w-1:0]         ptr_r, grant, idx, owner_r;
  logic                     grant_v;
  logic [addr_width_p-1:0]  addr_r;
  logic                     wr_r;
  logic [1:0]               size_r;
  logic [axis_width_p-1:0]  data_r, rdata_r;
  logic [num_req_p-1:0]     ready_c, resp_v_c;
  logic [axis_width_p-1:0]  resp_data_c;
  logic                     resp_err_c, wen_c, ren_c, expire;

`ifdef ETH_MMIO_ARB_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout_cycles_p + 1);
  logic [cnt_w-1:0] cnt_r;
  logic             err_r;
  // a valid in the expiry cycle takes priority, so expiry requires silence
  assign expire = (state_r == RWAIT) && !bus.read_data_v_i &&
                  (cnt_r == cnt_w'(timeout_cycles_p - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (timeout_cycles_p > 0);
  assign expire     = 1'b0;
`endif

  // round-robin search: first valid requester after the last grant, wrapping
  always_comb begin
    grant   = '0;
    grant_v = 1'b0;
    idx     = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      idx = ptr_w'((int'(ptr_r) + k) % num_req_p);
      if (!grant_v && bus.req_v_i[idx]) begin
        grant   = idx;
        grant_v = 1'b1;
      end
    end
  end

  // next state and per-state outputs
  always_comb begin
    state_n     = state_r;
    ready_c     = '0;
    resp_v_c    = '0;
    resp_data_c = '0;
    resp_err_c  = 1'b0;
    wen_c       = 1'b0;
    ren_c       = 1'b0;
    case (state_r)
      IDLE: if (grant_v) begin
        ready_c[grant] = 1'b1;
        state_n        = ISSUE;
      end
      ISSUE: begin
        wen_c   = wr_r;
        ren_c   = !wr_r;
        state_n = wr_r ? WACK : RWAIT;
      end
      WACK: begin
        resp_v_c[owner_r] = 1'b1;
        state_n           = IDLE;
      end
      RWAIT: if (bus.read_data_v_i || expire) state_n = RRESP;
      RRESP: begin
        resp_v_c[owner_r] = 1'b1;
        resp_data_c       = rdata_r;
`ifdef ETH_MMIO_ARB_TIMEOUT_EN
        resp_err_c        = err_r;
`endif
        state_n           = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, rr pointer, op latches and read-data capture
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ptr_r   <= ptr_w'(num_req_p - 1);
      owner_r <= '0;
      addr_r  <= '0;
      wr_r    <= 1'b0;
      size_r  <= '0;
      data_r  <= '0;
      rdata_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == IDLE && grant_v) begin
        ptr_r   <= grant;
        owner_r <= grant;
        addr_r  <= bus.req_addr_i[grant];
        wr_r    <= bus.req_write_i[grant];
        size_r  <= bus.req_op_size_i[grant];
        data_r  <= bus.req_data_i[grant];
      end
      if (state_r == RWAIT && bus.read_data_v_i) rdata_r <= bus.read_data_i;
      else if (expire)                            rdata_r <= '1;
    end
  end

`ifdef ETH_MMIO_ARB_TIMEOUT_EN
  // wait counter restarts for every read; err flag marks a timed-out completion
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (state_r == ISSUE)      cnt_r <= '0;
      else if (state_r == RWAIT) cnt_r <= cnt_r + 1'b1;
      if (state_r == RWAIT && bus.read_data_v_i) err_r <= 1'b0;
      else if (expire)                            err_r <= 1'b1;
    end
  end
`endif

  assign bus.req_ready_o  = ready_c;
  assign bus.resp_v_o     = resp_v_c;
  assign bus.resp_data_o  = resp_data_c;
  assign bus.resp_err_o   = resp_err_c;
  assign bus.write_en_o   = wen_c;
  assign bus.read_en_o    = ren_c;
  assign bus.addr_o       = addr_r;
  assign bus.op_size_o    = size_r;
  assign bus.write_data_o = data_r;
endmodule
